// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per clock with a registered carry.
// Define SERIAL_ADD_SUB_OVF_EN to build the signed overflow flag; otherwise Ovf is tied to 0.
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             Cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_chunk
            $error("serial_add_sub: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
    logic               carry_q, carry_d, cout_q, cout_d, busy_q, busy_d, done_q, done_d;
    logic [CHUNK-1:0]   a_chunk, b_chunk;
    logic [CHUNK:0]     chunk_sum;
    int                 base;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic               ovf_q, ovf_d;
    logic               msb_cin;
`endif

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        base      = int'(idx_q) * CHUNK;
        a_chunk   = a_q[base +: CHUNK];
        b_chunk   = b_q[base +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
        // Carry into the MSB recovered from the MSB's own sum bit.
        msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = sub ? 1'b1 : Cin;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d              = chunk_sum[CHUNK];
                if (idx_q == IDX_W'(N - 1)) begin
                    idx_d   = '0;
                    s_d     = res_d;
                    cout_d  = chunk_sum[CHUNK];
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef SERIAL_ADD_SUB_OVF_EN
                    ovf_d   = msb_cin ^ chunk_sum[CHUNK];
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
    assign Ovf  = ovf_q;
`else
    assign Ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub: WIDTH=16/CHUNK=4 instance plus a CHUNK=WIDTH instance.
module tb_serial_add_sub;

    logic        clk = 1'b0;
    logic        rst, start, start2, sub, Cin;
    logic [15:0] A, B;
    logic [15:0] S, S2;
    logic        Cout, Ovf, busy, done;
    logic        Cout2, Ovf2, busy2, done2;
    int          n_checks = 0;
    int          n_fail   = 0;

`ifdef SERIAL_ADD_SUB_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .Cin(Cin), .A(A), .B(B),
        .S(S), .Cout(Cout), .Ovf(Ovf), .busy(busy), .done(done)
    );

    serial_add_sub #(.WIDTH(16), .CHUNK(16)) dut_n1 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub), .Cin(Cin), .A(A), .B(B),
        .S(S2), .Cout(Cout2), .Ovf(Ovf2), .busy(busy2), .done(done2)
    );

    // Issues one operation and returns the number of edges after the start edge until done is seen.
    task automatic run_op(input bit which, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c, output int cycles);
        @(negedge clk);
        A = a; B = b; sub = s; Cin = c;
        if (which) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start2 = 1'b0;
        cycles = 0;
        while (((which ? done2 : done) !== 1'b1) && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0; sub = 1'b0; Cin = 1'b0; A = '0; B = '0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({S, Cout, Ovf, busy, done} !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_hold: got S=%h C=%b O=%b busy=%b done=%b, want all 0", S, Cout, Ovf, busy, done);
            end
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if ({S, Cout, Ovf, busy, done, S2, Cout2, Ovf2, busy2, done2} !== 40'h0) begin
                n_fail++;
                $display("FAIL idle: got S=%h C=%b O=%b busy=%b done=%b, want all 0", S, Cout, Ovf, busy, done);
            end
        end
    endtask

    task automatic test_add();
        int cyc;
        run_op(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0, cyc);
        n_checks++;
        if (cyc !== 4) begin n_fail++; $display("FAIL add_latency: got %0d edges, want 4", cyc); end
        n_checks++;
        if ({S, Cout, Ovf, busy} !== {16'h5555, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_result: got S=%h C=%b O=%b busy=%b, want 5555 0 0 1", S, Cout, Ovf, busy);
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy, S} !== {1'b0, 1'b0, 16'h5555}) begin
            n_fail++;
            $display("FAIL add_after: got done=%b busy=%b S=%h, want 0 0 5555", done, busy, S);
        end
    endtask

    task automatic test_ripple();
        int cyc;
        run_op(1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, cyc);
        n_checks++;
        if ({cyc == 4, S, Cout, Ovf} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ripple_carry: got cyc=%0d S=%h C=%b O=%b, want 4 0000 1 0", cyc, S, Cout, Ovf);
        end
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, cyc);
        n_checks++;
        if ({cyc == 4, S, Cout, Ovf} !== {1'b1, 16'h8000, 1'b0, OVF_ON}) begin
            n_fail++;
            $display("FAIL add_ovf: got cyc=%0d S=%h C=%b O=%b, want 4 8000 0 %b", cyc, S, Cout, Ovf, OVF_ON);
        end
    endtask

    task automatic test_sub();
        int cyc;
        run_op(1'b0, 16'h0005, 16'h0007, 1'b1, 1'b1, cyc);
        n_checks++;
        if ({cyc == 4, S, Cout, Ovf} !== {1'b1, 16'hFFFE, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_borrow: got cyc=%0d S=%h C=%b O=%b, want 4 fffe 0 0", cyc, S, Cout, Ovf);
        end
        run_op(1'b0, 16'h8000, 16'h0001, 1'b1, 1'b0, cyc);
        n_checks++;
        if ({cyc == 4, S, Cout, Ovf} !== {1'b1, 16'h7FFF, 1'b1, OVF_ON}) begin
            n_fail++;
            $display("FAIL sub_ovf: got cyc=%0d S=%h C=%b O=%b, want 4 7fff 1 %b", cyc, S, Cout, Ovf, OVF_ON);
        end
    endtask

    task automatic test_protocol();
        int pulses = 0;
        int cyc;
        @(negedge clk);
        A = 16'h0001; B = 16'h0001; sub = 1'b0; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 16'hAAAA;
        n_checks++;
        if ({busy, done, S} !== {1'b1, 1'b0, 16'h7FFF}) begin
            n_fail++;
            $display("FAIL hold_prev: got busy=%b done=%b S=%h, want 1 0 7fff", busy, done, S);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_checks++;
        if ({S, done} !== {16'h0002, 1'b1}) begin
            n_fail++;
            $display("FAIL ignore_start: got S=%h done=%b, want 0002 1", S, done);
        end
        @(negedge clk);
        start = 1'b0;
        if (done === 1'b1) pulses++;
        n_checks++;
        if (pulses !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got %0d pulses busy=%b, want 1 pulse busy=0", pulses, busy);
        end

        // Reset in the second RUN cycle discards the operation.
        @(negedge clk);
        A = 16'h1111; B = 16'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({S, Cout, Ovf, busy, done} !== 20'h0) begin
            n_fail++;
            $display("FAIL async_reset: got S=%h C=%b O=%b busy=%b done=%b, want all 0", S, Cout, Ovf, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({S, busy, done} !== 18'h0) begin
            n_fail++;
            $display("FAIL discarded: got S=%h busy=%b done=%b, want 0 0 0", S, busy, done);
        end
        run_op(1'b0, 16'h0003, 16'h0004, 1'b0, 1'b0, cyc);
        n_checks++;
        if ({cyc == 4, S, Cout} !== {1'b1, 16'h0007, 1'b0}) begin
            n_fail++;
            $display("FAIL after_reset: got cyc=%0d S=%h C=%b, want 4 0007 0", cyc, S, Cout);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, cyc);
        n_checks++;
        if ({cyc == 1, S2, Cout2, Ovf2} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL n1_result: got cyc=%0d S=%h C=%b O=%b, want 1 0000 1 0", cyc, S2, Cout2, Ovf2);
        end
        repeat (2) @(negedge clk);
        A = 16'h0005; B = 16'h0006; start2 = 1'b1;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            n_checks++;
            if (done2 !== ((j % 3) == 1)) begin
                n_fail++;
                $display("FAIL b2b_done[%0d]: got done=%b, want %b", j, done2, (j % 3) == 1);
            end
        end
        start2 = 1'b0;
        n_checks++;
        if ({S2, Cout2} !== {16'h000B, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_result: got S=%h C=%b, want 000b 0", S2, Cout2);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_ripple();
        test_sub();
        test_protocol();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "timeout");
    end

endmodule
